// File: rtl/mem_lsu_pkg.sv
// Shared load/store unit definitions: widths, funct3 codes, FSM encoding.
package mem_lsu_pkg;

    localparam int unsigned LSU_MEM_ADDR_W = 32;
    localparam int unsigned LSU_REG_DATA_W = 32;
    localparam int unsigned LSU_REG_ADDR_W = 5;
    localparam int unsigned LSU_BE_W       = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Stores accept B/H/W only; loads additionally accept the unsigned forms.
    function automatic logic legal_f3(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 inside {F3_B, F3_H, F3_W};
        end
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store byte enables / replication, load lane extraction
// and extension, and access legality (size alignment and funct3 code).
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_REG_DATA_W
) (
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr_lo,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [LSU_BE_W-1:0] be_c,
    output logic [DATA_W-1:0]   wdata_c,
    output logic [DATA_W-1:0]   load_data_c,
    output logic                err_c
);

    logic       misalign;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte enables and replicated write data, keyed by access size.
    always_comb begin
        be_c     = '0;
        wdata_c  = store_data;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be_c    = LSU_BE_W'(4'b0001 << addr_lo);
                wdata_c = {(DATA_W/8){store_data[7:0]}};
            end
            2'b01: begin
                be_c     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {(DATA_W/16){store_data[15:0]}};
                misalign = addr_lo[0];
            end
            2'b10: begin
                be_c     = 4'b1111;
                misalign = |addr_lo;
            end
            default: be_c = '0;
        endcase
        err_c = misalign | ~legal_f3(is_store, funct3);
    end

    // Pick the addressed lane from the returned word and extend it.
    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data_c = {{(DATA_W-8){lane_b[7]}}, lane_b};
            F3_BU:   load_data_c = {{(DATA_W-8){1'b0}}, lane_b};
            F3_H:    load_data_c = {{(DATA_W-16){lane_h[15]}}, lane_h};
            F3_HU:   load_data_c = {{(DATA_W-16){1'b0}}, lane_h};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: data-bus handshake FSM, pipeline hold, MEM/WB registers.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = LSU_MEM_ADDR_W,
    parameter int unsigned REG_DATA_W = LSU_REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_wmem_en_i,
    input  logic                      mem_rmem_en_i,
    input  logic [MEM_ADDR_W-1:0]     mem_mem_addr_i,
    input  logic [2:0]                mem_funct3_i,
    input  logic [REG_DATA_W-1:0]     mem_store_data_i,
    input  logic                      mem_wreg_en_i,
    input  logic [LSU_REG_ADDR_W-1:0] mem_wreg_addr_i,
    input  logic [REG_DATA_W-1:0]     mem_wreg_data_i,
    output logic                      dbus_req_o,
    output logic                      dbus_we_o,
    output logic [MEM_ADDR_W-1:0]     dbus_addr_o,
    output logic [REG_DATA_W-1:0]     dbus_wdata_o,
    output logic [LSU_BE_W-1:0]       dbus_be_o,
    input  logic                      dbus_gnt_i,
    input  logic                      dbus_rvalid_i,
    input  logic [REG_DATA_W-1:0]     dbus_rdata_i,
    output logic                      hold_o,
    output logic                      wb_wreg_en_o,
    output logic [LSU_REG_ADDR_W-1:0] wb_wreg_addr_o,
    output logic [REG_DATA_W-1:0]     wb_wreg_data_o,
    output logic                      err_o
);

    lsu_state_e            state;
    lsu_state_e            state_nxt;
    logic                  access;
    logic                  is_store;
    logic                  align_err;
    logic                  access_err;
    logic                  load_done;
    logic [REG_DATA_W-1:0] load_data;

    assign access       = mem_wmem_en_i | mem_rmem_en_i;
    assign is_store     = mem_wmem_en_i;
    assign dbus_we_o    = is_store;
    assign dbus_addr_o  = {mem_mem_addr_i[MEM_ADDR_W-1:2], 2'b00};
    assign load_done    = (state == ST_WAIT) && dbus_rvalid_i;

    mem_lsu_align #(
        .DATA_W (REG_DATA_W)
    ) u_align (
        .is_store    (is_store),
        .funct3      (mem_funct3_i),
        .addr_lo     (mem_mem_addr_i[1:0]),
        .store_data  (mem_store_data_i),
        .rdata       (dbus_rdata_i),
        .be_c        (dbus_be_o),
        .wdata_c     (dbus_wdata_o),
        .load_data_c (load_data),
        .err_c       (align_err)
    );

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, bus request and hold; a granted store finishes in its grant cycle.
    always_comb begin
        state_nxt  = state;
        dbus_req_o = 1'b0;
        hold_o     = 1'b0;
        access_err = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (align_err) begin
                            access_err = 1'b1;
                        end else begin
                            dbus_req_o = 1'b1;
                            if (dbus_gnt_i) begin
                                state_nxt = is_store ? ST_IDLE : ST_WAIT;
                                hold_o    = ~is_store;
                            end else begin
                                state_nxt = ST_REQ;
                                hold_o    = 1'b1;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    dbus_req_o = 1'b1;
                    if (dbus_gnt_i) begin
                        state_nxt = is_store ? ST_IDLE : ST_WAIT;
                        hold_o    = ~is_store;
                    end else begin
                        hold_o = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dbus_rvalid_i) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        hold_o = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // MEM/WB registers: bubble while held or on error, load result or pass-through otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wreg_en_o   <= 1'b0;
            wb_wreg_addr_o <= '0;
            wb_wreg_data_o <= '0;
            err_o          <= 1'b0;
        end else begin
            err_o <= access_err;
            if (hold_o || access_err) begin
                wb_wreg_en_o <= 1'b0;
            end else if (load_done) begin
                wb_wreg_en_o   <= mem_wreg_en_i;
                wb_wreg_addr_o <= mem_wreg_addr_i;
                wb_wreg_data_o <= load_data;
            end else begin
                wb_wreg_en_o   <= mem_wreg_en_i;
                wb_wreg_addr_o <= mem_wreg_addr_i;
                wb_wreg_data_o <= mem_wreg_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: driver pushes model expectations, monitor pops and compares.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wmem_en_i, mem_rmem_en_i;
    logic [31:0] mem_mem_addr_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_store_data_i;
    logic        mem_wreg_en_i;
    logic [4:0]  mem_wreg_addr_i;
    logic [31:0] mem_wreg_data_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        hold_o;
    logic        wb_wreg_en_o;
    logic [4:0]  wb_wreg_addr_o;
    logic [31:0] wb_wreg_data_o;
    logic        err_o;

    mem_lsu #(.MEM_ADDR_W(32), .REG_DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_wmem_en_i    (mem_wmem_en_i),
        .mem_rmem_en_i    (mem_rmem_en_i),
        .mem_mem_addr_i   (mem_mem_addr_i),
        .mem_funct3_i     (mem_funct3_i),
        .mem_store_data_i (mem_store_data_i),
        .mem_wreg_en_i    (mem_wreg_en_i),
        .mem_wreg_addr_i  (mem_wreg_addr_i),
        .mem_wreg_data_i  (mem_wreg_data_i),
        .dbus_req_o       (dbus_req_o),
        .dbus_we_o        (dbus_we_o),
        .dbus_addr_o      (dbus_addr_o),
        .dbus_wdata_o     (dbus_wdata_o),
        .dbus_be_o        (dbus_be_o),
        .dbus_gnt_i       (dbus_gnt_i),
        .dbus_rvalid_i    (dbus_rvalid_i),
        .dbus_rdata_i     (dbus_rdata_i),
        .hold_o           (hold_o),
        .wb_wreg_en_o     (wb_wreg_en_o),
        .wb_wreg_addr_o   (wb_wreg_addr_o),
        .wb_wreg_data_o   (wb_wreg_data_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit err; bit [4:0] addr; bit [31:0] data; } wb_exp_t;
    typedef struct { bit we; bit [31:0] addr; bit [3:0] be; bit [31:0] wdata; } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit st, input bit [2:0] f3, input bit [31:0] a);
        bit code_ok;
        code_ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return code_ok && ((int'(a[1:0]) % acc_size(f3)) == 0);
    endfunction

    function automatic bit [3:0] model_be(input bit [2:0] f3, input bit [31:0] a);
        bit [3:0] be;
        int lo;
        be = '0;
        lo = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + acc_size(f3)) be[i] = 1'b1;
        end
        return be;
    endfunction

    function automatic bit [31:0] model_wdata(input bit [2:0] f3, input bit [31:0] d);
        bit [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = d[8*(i % acc_size(f3)) +: 8];
        end
        return w;
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
        bit [31:0] v;
        bit [31:0] m;
        int sz;
        sz = acc_size(f3);
        v  = rd >> (8 * int'(a[1:0]));
        if (sz < 4) begin
            m = 32'((64'd1 << (8 * sz)) - 64'd1);
            v = v & m;
            if (!f3[2] && v[8*sz-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic set_inputs(input bit st, input bit ld, input bit [2:0] f3, input bit [31:0] a,
                              input bit [31:0] sd, input bit we, input bit [4:0] wa, input bit [31:0] wd);
        mem_wmem_en_i    = st;
        mem_rmem_en_i    = ld;
        mem_funct3_i     = f3;
        mem_mem_addr_i   = a;
        mem_store_data_i = sd;
        mem_wreg_en_i    = we;
        mem_wreg_addr_i  = wa;
        mem_wreg_data_i  = wd;
    endtask

    // Issue one EX/MEM instruction, play the bus slave, hold inputs while hold_o is high.
    // gw = cycles with gnt low before grant; rvd = WAIT cycles before rvalid.
    task automatic run_op(input bit st, input bit ld, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] sd, input bit we, input bit [4:0] wa, input bit [31:0] wd,
                          input int gw, input int rvd, input bit [31:0] rd);
        bit ok;
        int exp_cyc;
        int c;
        int widx;
        wb_exp_t  we_e;
        bus_exp_t be_e;
        ok = (st || ld) && legal(st, f3, a);
        if ((st || ld) && !ok) begin
            we_e = '{err: 1'b1, addr: 5'd0, data: 32'd0};
            wb_q.push_back(we_e);
        end else if (we) begin
            we_e = '{err: 1'b0, addr: wa, data: (ok && !st) ? model_load(f3, a, rd) : wd};
            wb_q.push_back(we_e);
        end
        if (ok) begin
            be_e = '{we: st, addr: a & ~32'd3, be: model_be(f3, a), wdata: st ? model_wdata(f3, sd) : 32'd0};
            bus_q.push_back(be_e);
        end
        exp_cyc = !ok ? 0 : (st ? gw : gw + 1 + rvd);
        set_inputs(st, ld, f3, a, sd, we, wa, wd);
        c = 0;
        forever begin
            dbus_gnt_i = ok ? (c >= gw) : 1'($urandom_range(0, 1));
            widx = c - gw - 1;
            if (ok && !st && widx >= 0) begin
                dbus_rvalid_i = (widx == rvd);
                dbus_rdata_i  = (widx == rvd) ? rd : $urandom;
            end else begin
                dbus_rvalid_i = ($urandom_range(0, 3) == 0);
                dbus_rdata_i  = $urandom;
            end
            @(negedge clk);
            if (!hold_o) break;
            if (c >= 1) check("bubble_wb_en", 32'(wb_wreg_en_o), 32'd0);
            if (c >= 64) begin
                check("hold_timeout", 32'(hold_o), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
            c++;
        end
        check("hold_cycles", 32'(c), 32'(exp_cyc));
        @(posedge clk);
        #1;
    endtask

    // Monitor: bus requests against the bus queue head, wb/err events against the wb queue.
    initial begin
        wb_exp_t  we_m;
        bus_exp_t be_m;
        forever begin
            @(negedge clk);
            if (dbus_req_o) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", 32'(dbus_req_o), 32'd0);
                end else begin
                    be_m = bus_q[0];
                    check("bus_addr", dbus_addr_o, be_m.addr);
                    check("bus_we", 32'(dbus_we_o), 32'(be_m.we));
                    check("bus_be", 32'(dbus_be_o), 32'(be_m.be));
                    if (be_m.we) check("bus_wdata", dbus_wdata_o, be_m.wdata);
                    if (dbus_gnt_i) void'(bus_q.pop_front());
                end
            end
            if (!rst && (wb_wreg_en_o || err_o)) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 32'({wb_wreg_en_o, err_o}), 32'd0);
                end else begin
                    we_m = wb_q.pop_front();
                    check("wb_err", 32'(err_o), 32'(we_m.err));
                    if (we_m.err) begin
                        check("err_wb_en", 32'(wb_wreg_en_o), 32'd0);
                    end else begin
                        check("wb_addr", 32'(wb_wreg_addr_o), 32'(we_m.addr));
                        check("wb_data", wb_wreg_data_o, we_m.data);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Driver: reset, directed corner cases, then randomized traffic.
    initial begin
        bit st, ld, we;
        bit [2:0] f3;
        bit [31:0] a, sd, wd, rd;
        bit [4:0] wa;
        int kind;
        wb_exp_t we_d;
        bus_exp_t be_d;

        rst = 1'b1;
        set_inputs(1'b1, 1'b0, 3'b010, 32'h100, 32'h5, 1'b1, 5'd1, 32'h9);
        dbus_gnt_i = 1'b1;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(dbus_req_o), 32'd0);
            check("rst_hold", 32'(hold_o), 32'd0);
        end
        check("rst_wb_en", 32'(wb_wreg_en_o), 32'd0);
        check("rst_wb_addr", 32'(wb_wreg_addr_o), 32'd0);
        check("rst_wb_data", wb_wreg_data_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;

        // LB from lane 3 with immediate grant and next-cycle rvalid
        run_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0, 1'b1, 5'd10, 32'h0, 0, 0, 32'h80AABBCC);
        // SH upper half with grant held off three cycles
        run_op(1'b1, 1'b0, 3'b001, 32'h2002, 32'h1234ABCD, 1'b0, 5'd0, 32'h0, 3, 0, 32'h0);
        // Misaligned LW
        run_op(1'b0, 1'b1, 3'b010, 32'h3001, 32'h0, 1'b1, 5'd11, 32'hAA, 0, 0, 32'h0);
        // LHU with rvalid five cycles after grant
        run_op(1'b0, 1'b1, 3'b101, 32'h4002, 32'h0, 1'b1, 5'd12, 32'h0, 0, 4, 32'hF00D1234);
        // Back-to-back ALU results
        run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd5, 32'd7, 0, 0, 32'h0);
        check("alu_lat_addr", 32'(wb_wreg_addr_o), 32'd5);
        check("alu_lat_data", wb_wreg_data_o, 32'd7);
        run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd6, 32'd9, 0, 0, 32'h0);
        check("alu_lat_addr", 32'(wb_wreg_addr_o), 32'd6);
        check("alu_lat_data", wb_wreg_data_o, 32'd9);

        // Reset while a load waits for rvalid; the late rvalid must be ignored
        be_d = '{we: 1'b0, addr: 32'h5000, be: 4'hF, wdata: 32'h0};
        bus_q.push_back(be_d);
        set_inputs(1'b0, 1'b1, 3'b010, 32'h5000, 32'h0, 1'b1, 5'd9, 32'h1111);
        dbus_gnt_i = 1'b1;
        dbus_rvalid_i = 1'b0;
        @(negedge clk);
        check("rstw_hold_req", 32'(hold_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_inputs(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("rstw_req", 32'(dbus_req_o), 32'd0);
        check("rstw_hold", 32'(hold_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = 32'hDEADBEEF;
        set_inputs(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h55);
        we_d = '{err: 1'b0, addr: 5'd3, data: 32'h55};
        wb_q.push_back(we_d);
        @(negedge clk);
        check("rstw_hold_late_rv", 32'(hold_o), 32'd0);
        check("rstw_wb_en", 32'(wb_wreg_en_o), 32'd0);
        check("rstw_wb_addr", 32'(wb_wreg_addr_o), 32'd0);
        check("rstw_wb_data", wb_wreg_data_o, 32'd0);
        @(posedge clk);
        #1;
        dbus_rvalid_i = 1'b0;
        set_inputs(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;

        // Randomized mix of ALU ops, stores, loads and store+load collisions
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            sd = $urandom;
            wd = $urandom;
            rd = $urandom;
            wa = 5'($urandom);
            we = ($urandom_range(0, 3) != 0);
            st = (kind == 1) || (kind == 3);
            ld = (kind == 2) || (kind == 3);
            if (kind == 1) f3 = 3'($urandom_range(0, 3));
            run_op(st, ld, f3, a, sd, we, wa, wd, $urandom_range(0, 3), $urandom_range(0, 4), rd);
        end

        set_inputs(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
